// File: rtl/uart_in_responder.sv
`default_nettype none
// ============================================================================
// Module  : uart_in_responder
// Brief   : Console UART input responder. It buffers host-pushed characters
//           and answers DUT read strobes with the FIFO head, or 0xFF when no
//           character is offered. The optional macro
//           UART_IN_RESPONDER_STATS_EN adds delivered and empty-read counters.
// Revision: 1.0
// ============================================================================
module uart_in_responder #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0,
  parameter int GAP_W      = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_valid,
  input  logic [7:0]               push_data,
  output logic                     push_ready,
  input  logic                     uart_in_valid,
  output logic [7:0]               uart_in_ch,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_cnt
`ifdef UART_IN_RESPONDER_STATS_EN
  ,
  output logic [31:0]              delivered_cnt,
  output logic [31:0]              empty_read_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0]    FULL     = LW'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic [LW-1:0]    level_next;
  logic             offered;
  logic             pop;
  logic             push_acc;
  logic             store;

  assign offered    = (state == READY) && (level != '0);
  assign pop        = offered && uart_in_valid;
  // A same-edge pop frees a slot, so a full FIFO can still take a push.
  assign push_ready = (level < FULL) || pop;
  assign push_acc   = push_valid && push_ready;
  assign store      = push_acc && (push_data != 8'hFF);
  assign uart_in_ch = offered ? mem[rd_ptr] : 8'hFF;

  always_comb begin
    level_next = level;
    if (store && !pop) begin
      level_next = level + 1'b1;
    end else if (!store && pop) begin
      level_next = level - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (store) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      gap_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      level <= level_next;
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_acc && (push_data == 8'hFF) && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (store) begin
            state <= READY;
          end
        end
        READY: begin
          if (pop) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              state <= (level_next != '0) ? READY : IDLE;
            end
          end
        end
        GAP: begin
          // Leave on the edge where the counter passes from 1 to 0.
          if (gap_cnt <= GAP_LAST) begin
            gap_cnt <= '0;
            state   <= (level_next != '0) ? READY : IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_IN_RESPONDER_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      delivered_cnt  <= '0;
      empty_read_cnt <= '0;
    end else begin
      if (pop) begin
        delivered_cnt <= delivered_cnt + 32'd1;
      end
      if (uart_in_valid && !offered) begin
        empty_read_cnt <= empty_read_cnt + 32'd1;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset_n && pop) begin
      $display("uart_in_responder: delivered 0x%02h", uart_in_ch);
    end
  end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_in_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_in_responder
// Brief   : Self-checking bench. u0 runs back-to-back delivery (GAP 0) and
//           u3 runs with a 3-cycle gap between delivered characters.
// Revision: 1.0
// ============================================================================
module tb_uart_in_responder;

  localparam int DEPTH = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       pv0, rv0, pv3, rv3;
  logic [7:0] pd0, pd3;
  logic       pr0, pr3;
  logic [7:0] ch0, ch3;
  logic [4:0] lv0, lv3;
  logic [15:0] dc0, dc3;
`ifdef UART_IN_RESPONDER_STATS_EN
  logic [31:0] del0, emp0, del3, emp3;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  int drops = 0;

  typedef struct {
    logic       pv;
    logic [7:0] pd;
    logic       rv;
    logic [7:0] ch;
    logic [4:0] lv;
    logic       pr;
  } vec_t;
  vec_t vecs[12];

  uart_in_responder #(.DEPTH(DEPTH), .GAP_CYCLES(0), .GAP_W(16)) u0 (
    .clock(clock), .reset_n(reset_n),
    .push_valid(pv0), .push_data(pd0), .push_ready(pr0),
    .uart_in_valid(rv0), .uart_in_ch(ch0), .level(lv0), .drop_cnt(dc0)
`ifdef UART_IN_RESPONDER_STATS_EN
    , .delivered_cnt(del0), .empty_read_cnt(emp0)
`endif
  );

  uart_in_responder #(.DEPTH(DEPTH), .GAP_CYCLES(3), .GAP_W(16)) u3 (
    .clock(clock), .reset_n(reset_n),
    .push_valid(pv3), .push_data(pd3), .push_ready(pr3),
    .uart_in_valid(rv3), .uart_in_ch(ch3), .level(lv3), .drop_cnt(dc3)
`ifdef UART_IN_RESPONDER_STATS_EN
    , .delivered_cnt(del3), .empty_read_cnt(emp3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compare u0 against the queue model, update the model, then clock.
  task automatic tick0();
    logic exp_ready;
    exp_ready = (q.size() < DEPTH) || (rv0 && (q.size() > 0));
    check("sb_level", 32'(lv0), 32'(q.size()));
    check("sb_ch", 32'(ch0), (q.size() > 0) ? 32'(q[0]) : 32'hFF);
    check("sb_ready", 32'(pr0), 32'(exp_ready));
    if (rv0 && (q.size() > 0)) begin
      void'(q.pop_front());
    end
    if (pv0 && exp_ready) begin
      if (pd0 == 8'hFF) drops++;
      else q.push_back(pd0);
    end
    tick();
  endtask

  task automatic cyc0(input logic pv, input logic [7:0] pd, input logic rv);
    pv0 = pv; pd0 = pd; rv0 = rv;
    #2;
    tick0();
  endtask

  logic [7:0] exp3 [13];

  initial begin
    reset_n = 1'b0;
    pv0 = 1'b0; pd0 = 8'h00; rv0 = 1'b0;
    pv3 = 1'b0; pd3 = 8'h00; rv3 = 1'b0;
    #12 reset_n = 1'b1;
    tick();

    // Reset state, then idle reads return 0xFF.
    check("rst_drop", 32'(dc0), 32'd0);
    for (int i = 0; i < 5; i++) cyc0(1'b0, 8'h00, 1'b1);

    // 'h','i' then reads, and the 0xFF drop case.
    vecs[0]  = '{1'b1, 8'h68, 1'b0, 8'hFF, 5'd0, 1'b1};
    vecs[1]  = '{1'b1, 8'h69, 1'b0, 8'h68, 5'd1, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 8'h68, 5'd2, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 8'h69, 5'd1, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'hFF, 5'd0, 1'b1};
    vecs[5]  = '{1'b1, 8'h41, 1'b0, 8'hFF, 5'd0, 1'b1};
    vecs[6]  = '{1'b1, 8'hFF, 1'b0, 8'h41, 5'd1, 1'b1};
    vecs[7]  = '{1'b1, 8'h42, 1'b0, 8'h41, 5'd1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h41, 5'd2, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'h42, 5'd1, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 8'hFF, 5'd0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 8'hFF, 5'd0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      pv0 = vecs[i].pv; pd0 = vecs[i].pd; rv0 = vecs[i].rv;
      #2;
      check($sformatf("vec%0d_ch", i), 32'(ch0), 32'(vecs[i].ch));
      check($sformatf("vec%0d_level", i), 32'(lv0), 32'(vecs[i].lv));
      check($sformatf("vec%0d_ready", i), 32'(pr0), 32'(vecs[i].pr));
      tick0();
    end
    check("drop_cnt", 32'(dc0), 32'd1);
    check("drop_model", 32'(dc0), 32'(drops));

    // Gap of 3 idle cycles between delivered characters.
    pv3 = 1'b1; pd3 = 8'h61; tick();
    pd3 = 8'h62; tick();
    pd3 = 8'h63; tick();
    pv3 = 1'b0; rv3 = 1'b1;
    exp3 = '{8'h61, 8'hFF, 8'hFF, 8'hFF, 8'h62, 8'hFF, 8'hFF, 8'hFF,
             8'h63, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 13; i++) begin
      #2;
      check($sformatf("gap_ch%0d", i), 32'(ch3), 32'(exp3[i]));
      tick();
    end
    rv3 = 1'b0;
    check("gap_level_end", 32'(lv3), 32'd0);

    // Fill to DEPTH, then push and pop on the same edge while full.
    for (int i = 0; i < DEPTH; i++) cyc0(1'b1, 8'h30 + 8'(i), 1'b0);
    pv0 = 1'b1; pd0 = 8'h60; rv0 = 1'b0;
    #2;
    check("full_ready", 32'(pr0), 32'd0);
    check("full_level", 32'(lv0), 32'd16);
    tick0();
    pv0 = 1'b1; pd0 = 8'h50; rv0 = 1'b1;
    #2;
    check("full_swap_ready", 32'(pr0), 32'd1);
    check("full_swap_ch", 32'(ch0), 32'h30);
    tick0();
    cyc0(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cyc0(1'b0, 8'h00, 1'b1);

    // Asynchronous reset while u3 sits in its gap.
    for (int i = 0; i < 4; i++) begin
      pv3 = 1'b1; pd3 = 8'h70 + 8'(i); tick();
    end
    pv3 = 1'b0; rv3 = 1'b1;
    #2;
    check("pre_rst_ch", 32'(ch3), 32'h70);
    tick();
    rv3 = 1'b0;
    #1;
    check("pre_rst_level", 32'(lv3), 32'd3);
    #1 reset_n = 1'b0;
    #1;
    check("arst_level", 32'(lv3), 32'd0);
    check("arst_ch", 32'(ch3), 32'hFF);
    check("arst_ready", 32'(pr3), 32'd1);
    check("arst_drop0", 32'(dc0), 32'd0);
    q.delete();
    drops = 0;
    @(posedge clock);
    #3 reset_n = 1'b1;
    tick();
    rv3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      check($sformatf("post_rst_ch%0d", i), 32'(ch3), 32'hFF);
      tick();
    end
    rv3 = 1'b0; pv3 = 1'b1; pd3 = 8'h7A;
    tick();
    pv3 = 1'b0; rv3 = 1'b1;
    #2;
    check("post_rst_new", 32'(ch3), 32'h7A);
    tick();
    #2;
    check("post_rst_gap", 32'(ch3), 32'hFF);
    rv3 = 1'b0;
    cyc0(1'b0, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
